// File: rtl/cp0_regfile_gen.sv
// Coprocessor-0 register file for the OpenMIPS MEM/WB stage: timer, interrupt
// sampling, exception/ERET bookkeeping and mfc0/mtc0 access.
module cp0_regfile_gen #(
    parameter int          INT_W        = 6,
    parameter int          COUNT_DIV    = 1,
    parameter logic [31:0] STATUS_WMASK = 32'h0000FF03,
    parameter logic [31:0] PRID_VAL     = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL   = 32'h00008000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [4:0]       waddr_i,
    input  logic [4:0]       raddr_i,
    input  logic [31:0]      data_i,
    input  logic [INT_W-1:0] int_i,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_code_i,
    input  logic             eret_i,
    input  logic [31:0]      current_inst_addr_i,
    input  logic             is_in_delayslot_i,
    input  logic [31:0]      badvaddr_i,
    output logic [31:0]      data_o,
    output logic [31:0]      count_o,
    output logic [31:0]      compare_o,
    output logic [31:0]      status_o,
    output logic [31:0]      cause_o,
    output logic [31:0]      epc_o,
    output logic [31:0]      badvaddr_o,
    output logic             timer_int_o,
    output logic             int_pending_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [7:0] PRESC_LAST = 8'(COUNT_DIV - 1);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [7:0]  r_presc;
    logic        r_timer;
    logic        r_cause_bd;
    logic [7:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_eret;
    logic        w_timer_match;
    logic        w_bad_addr_exc;
    logic [5:0]  w_ip_hw;
    logic [31:0] w_status_next;
    logic [31:0] w_cause;

    assign w_wr_count     = we_i && (waddr_i == REG_COUNT);
    assign w_wr_compare   = we_i && (waddr_i == REG_COMPARE);
    assign w_wr_status    = we_i && (waddr_i == REG_STATUS);
    assign w_wr_cause     = we_i && (waddr_i == REG_CAUSE);
    assign w_wr_epc       = we_i && (waddr_i == REG_EPC);
    assign w_eret         = eret_i && !exc_valid_i;
    assign w_timer_match  = (r_count == r_compare) && (r_compare != 32'd0);
    assign w_bad_addr_exc = (exc_code_i == 5'd4) || (exc_code_i == 5'd5);

    // Hardware lines land on IP[7:2]; lines beyond INT_W read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ip
            if (gi < INT_W) begin : g_used
                assign w_ip_hw[gi] = int_i[gi];
            end else begin : g_unused
                assign w_ip_hw[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_status_next = r_status;
        if (w_wr_status) begin
            w_status_next = (r_status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        end
        // EXL ownership: exception beats ERET beats mtc0.
        if (exc_valid_i) begin
            w_status_next[1] = 1'b1;
        end else if (w_eret) begin
            w_status_next[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 32'd0;
            r_presc <= 8'd0;
        end else if (w_wr_count) begin
            r_count <= data_i;
            r_presc <= 8'd0;
        end else if (r_presc == PRESC_LAST) begin
            r_count <= r_count + 32'd1;
            r_presc <= 8'd0;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_compare <= 32'd0;
            r_timer   <= 1'b0;
        end else begin
            if (w_wr_compare) begin
                r_compare <= data_i;
                r_timer   <= 1'b0;
            end else if (w_timer_match) begin
                r_timer <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status    <= 32'h10000000;
            r_epc       <= 32'd0;
            r_badvaddr  <= 32'd0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 8'd0;
            r_cause_exc <= 5'd0;
        end else begin
            r_status <= w_status_next;
            // IP7 also carries the timer, using the registered timer flag.
            r_cause_ip[7:2] <= {w_ip_hw[5] | r_timer, w_ip_hw[4:0]};
            if (w_wr_cause) begin
                r_cause_ip[1:0] <= data_i[9:8];
            end
            if (exc_valid_i) begin
                r_cause_exc <= exc_code_i;
                if (!r_status[1]) begin
                    r_epc      <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                    : current_inst_addr_i;
                    r_cause_bd <= is_in_delayslot_i;
                end
                if (w_bad_addr_exc) begin
                    r_badvaddr <= badvaddr_i;
                end
            end else if (w_wr_epc) begin
                r_epc <= data_i;
            end
        end
    end

    assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 1'b0, r_cause_exc, 2'b00};

    always_comb begin
        data_o = 32'd0;
        if (!rst) begin
            case (raddr_i)
                REG_BADVADDR: data_o = r_badvaddr;
                REG_COUNT:    data_o = r_count;
                REG_COMPARE:  data_o = r_compare;
                REG_STATUS:   data_o = r_status;
                REG_CAUSE:    data_o = w_cause;
                REG_EPC:      data_o = r_epc;
                REG_PRID:     data_o = PRID_VAL;
                REG_CONFIG:   data_o = CONFIG_VAL;
                default:      data_o = 32'd0;
            endcase
        end
    end

    assign count_o       = r_count;
    assign compare_o     = r_compare;
    assign status_o      = r_status;
    assign cause_o       = w_cause;
    assign epc_o         = r_epc;
    assign badvaddr_o    = r_badvaddr;
    assign timer_int_o   = r_timer;
    assign int_pending_o = r_status[0] & ~r_status[1] & (|(w_cause[15:8] & r_status[15:8]));

endmodule

// File: tb/tb_cp0_regfile_gen.sv
// Directed bench for cp0_regfile_gen: one instance with COUNT_DIV=1, a second
// with COUNT_DIV=4 checking only the prescaled Count.
module tb_cp0_regfile_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] badvaddr_i;

    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o, int_pending_o;

    logic [31:0] d4_data, d4_count, d4_compare, d4_status, d4_cause, d4_epc, d4_badvaddr;
    logic        d4_timer, d4_pend;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cp0_regfile_gen #(.INT_W(6), .COUNT_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .exc_valid_i(exc_valid_i),
        .exc_code_i(exc_code_i), .eret_i(eret_i),
        .current_inst_addr_i(current_inst_addr_i),
        .is_in_delayslot_i(is_in_delayslot_i), .badvaddr_i(badvaddr_i),
        .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o),
        .int_pending_o(int_pending_o)
    );

    cp0_regfile_gen #(.INT_W(6), .COUNT_DIV(4)) u_dut_div4 (
        .clk(clk), .rst(rst), .we_i(1'b0), .waddr_i(5'd0), .raddr_i(5'd0),
        .data_i(32'd0), .int_i(6'd0), .exc_valid_i(1'b0),
        .exc_code_i(5'd0), .eret_i(1'b0),
        .current_inst_addr_i(32'd0),
        .is_in_delayslot_i(1'b0), .badvaddr_i(32'd0),
        .data_o(d4_data), .count_o(d4_count), .compare_o(d4_compare),
        .status_o(d4_status), .cause_o(d4_cause), .epc_o(d4_epc),
        .badvaddr_o(d4_badvaddr), .timer_int_o(d4_timer),
        .int_pending_o(d4_pend)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
        we_i = 1'b1; waddr_i = addr; data_i = val;
        tick();
        we_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = 5'd15; data_i = '0;
        int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; eret_i = 1'b0;
        current_inst_addr_i = '0; is_in_delayslot_i = 1'b0; badvaddr_i = '0;

        tick(3);
        check_val("rd_in_reset", data_o, 32'h0);
        check_val("status_rst", status_o, 32'h10000000);
        check_val("timer_rst", {31'd0, timer_int_o}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("count_rst", count_o, 32'd0);
        raddr_i = 5'd12; #1;
        check_val("rd_status", data_o, 32'h10000000);
        raddr_i = 5'd15; #1;
        check_val("rd_prid", data_o, 32'h004C0102);
        raddr_i = 5'd16; #1;
        check_val("rd_config", data_o, 32'h00008000);
        raddr_i = 5'd3; #1;
        check_val("rd_unmapped", data_o, 32'h0);

        tick();
        check_val("count_div1_t1", count_o, 32'd1);
        check_val("count_div4_t1", d4_count, 32'd0);
        tick(2);
        check_val("count_div1_t3", count_o, 32'd3);
        check_val("count_div4_t3", d4_count, 32'd0);
        tick();
        check_val("count_div4_t4", d4_count, 32'd1);
        tick(4);
        check_val("count_div4_t8", d4_count, 32'd2);

        // Timer
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        check_val("count_load", count_o, 32'd10);
        tick(10);
        check_val("count_at_cmp", count_o, 32'd20);
        check_val("timer_pre", {31'd0, timer_int_o}, 32'd0);
        tick();
        check_val("timer_set", {31'd0, timer_int_o}, 32'd1);
        tick();
        check_val("cause_ip7", cause_o, 32'h00008000);
        mtc0(5'd11, 32'd50);
        check_val("timer_clr", {31'd0, timer_int_o}, 32'd0);
        check_val("compare50", compare_o, 32'd50);
        mtc0(5'd11, 32'd0);
        tick();
        check_val("cause_ip7_clr", cause_o, 32'h0);

        // Interrupt pending
        int_i = 6'b000100;
        mtc0(5'd12, 32'h0000FF01);
        check_val("status_mask", status_o, 32'h1000FF01);
        check_val("cause_ip4", cause_o, 32'h00001000);
        check_val("int_pend", {31'd0, int_pending_o}, 32'd1);

        // Address-error exception in delay slot
        exc_valid_i = 1'b1; exc_code_i = 5'd4; current_inst_addr_i = 32'h100;
        is_in_delayslot_i = 1'b1; badvaddr_i = 32'hBAD0;
        tick();
        exc_valid_i = 1'b0; is_in_delayslot_i = 1'b0;
        check_val("epc_ds", epc_o, 32'hFC);
        check_val("cause_exc4", cause_o, 32'h80001010);
        check_val("status_exl", status_o, 32'h1000FF03);
        check_val("badvaddr", badvaddr_o, 32'hBAD0);
        check_val("int_pend_exl", {31'd0, int_pending_o}, 32'd0);

        // Nested exception keeps EPC/BD
        exc_valid_i = 1'b1; exc_code_i = 5'd8; current_inst_addr_i = 32'h200;
        badvaddr_i = 32'h1111;
        tick();
        exc_valid_i = 1'b0;
        check_val("epc_nested", epc_o, 32'hFC);
        check_val("cause_exc8", cause_o, 32'h80001020);
        check_val("badvaddr_keep", badvaddr_o, 32'hBAD0);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        check_val("status_eret", status_o, 32'h1000FF01);
        check_val("int_pend_eret", {31'd0, int_pending_o}, 32'd1);

        // Exception and mtc0 Status in the same cycle
        exc_valid_i = 1'b1; exc_code_i = 5'd12; current_inst_addr_i = 32'h300;
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000AA00;
        tick();
        exc_valid_i = 1'b0; we_i = 1'b0;
        check_val("status_exc_mtc0", status_o, 32'h1000AA02);
        check_val("epc_nods", epc_o, 32'h300);
        check_val("cause_exc12", cause_o, 32'h00001030);

        // No bypass on mfc0 during mtc0
        raddr_i = 5'd14;
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h1234; #1;
        check_val("rd_no_bypass", data_o, 32'h300);
        tick();
        we_i = 1'b0;
        check_val("rd_epc_new", data_o, 32'h1234);
        mtc0(5'd15, 32'h0);
        raddr_i = 5'd15; #1;
        check_val("prid_ro", data_o, 32'h004C0102);
        mtc0(5'd13, 32'hFFFFFFFF);
        check_val("cause_sw_ip", cause_o, 32'h00001330);

        // Count wrap
        mtc0(5'd9, 32'hFFFFFFFF);
        check_val("count_max", count_o, 32'hFFFFFFFF);
        tick();
        check_val("count_wrap", count_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
